// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   MULT/MULTU use a shift-add multiplier over a 2*WIDTH accumulator.
//   DIV/DIVU use a restoring divider with a (WIDTH+1)-bit partial remainder.
//   Signed operations run on magnitudes; the sign is fixed up in the final
//   cycle. An operation takes 33 cycles from the start edge to the result.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   request a new operation (sampled only in IDLE)
//   op     in   2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU
//   a      in   multiplicand / dividend
//   b      in   multiplier / divisor
//   mthi   in   write wdata to HI (only when not busy)
//   mtlo   in   write wdata to LO (only when not busy)
//   wdata  in   data for MTHI/MTLO
//   busy   out  operation in progress (CALC or FIX)
//   done   out  one-cycle pulse, hi/lo hold the new result
//   hi     out  HI register (upper product / remainder)
//   lo     out  LO register (lower product / quotient)
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

  // Magnitude of x when the operation is signed and x is negative.
  function automatic logic [WIDTH-1:0] abs_if(input logic [WIDTH-1:0] x,
                                              input logic             is_signed);
    logic [WIDTH-1:0] r;
    if (is_signed && x[WIDTH-1]) begin
      r = -x;
    end else begin
      r = x;
    end
    return r;
  endfunction

  logic [1:0]         state_r;
  logic [5:0]         cnt_r;
  logic               is_div_r;
  logic               neg_xor_r;   // result sign: sign(a) ^ sign(b)
  logic               neg_a_r;     // dividend was negative: remainder sign
  logic [WIDTH-1:0]   mcand_r;     // multiplicand, or divisor for divides
  logic [WIDTH-1:0]   a_orig_r;    // raw dividend, returned on divide by zero
  logic [2*WIDTH-1:0] acc_r;       // product, or {unused, dividend/quotient}
  logic [WIDTH:0]     rem_r;       // partial remainder
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               op_signed_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH:0]     rem_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   remf_s;
  logic [WIDTH-1:0]   res_hi_s;
  logic [WIDTH-1:0]   res_lo_s;

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

  // Operand magnitudes captured at the start edge (op[0] = 0 means signed).
  always_comb begin
    op_signed_s = ~op[0];
    a_mag_s     = abs_if(a, op_signed_s);
    b_mag_s     = abs_if(b, op_signed_s);
  end

  // One iteration step: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_r[WIDTH-1:0], acc_r[WIDTH-1]};
    div_trial_s = {1'b0, div_shift_s} - {2'b00, mcand_r};
    acc_next_s  = acc_r;
    rem_next_s  = rem_r;
    if (is_div_r) begin
      // Non-negative trial difference means the divisor fits: quotient bit 1.
      if (!div_trial_s[WIDTH+1]) begin
        rem_next_s = div_trial_s[WIDTH:0];
        acc_next_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_next_s = div_shift_s;
        acc_next_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      rem_next_s = rem_r;
      acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied in the FIX cycle.
  always_comb begin
    if (neg_xor_r) begin
      prod_s = -acc_r;
      quot_s = -acc_r[WIDTH-1:0];
    end else begin
      prod_s = acc_r;
      quot_s = acc_r[WIDTH-1:0];
    end
    if (neg_a_r) begin
      remf_s = -rem_r[WIDTH-1:0];
    end else begin
      remf_s = rem_r[WIDTH-1:0];
    end
    if (!is_div_r) begin
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end else if (mcand_r == {WIDTH{1'b0}}) begin
      res_hi_s = a_orig_r;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = remf_s;
      res_lo_s = quot_s;
    end
  end

  // Control FSM, datapath registers and the HI/LO pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      is_div_r  <= 1'b0;
      neg_xor_r <= 1'b0;
      neg_a_r   <= 1'b0;
      mcand_r   <= {WIDTH{1'b0}};
      a_orig_r  <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Moves land on this edge even when start is also high; the
          // result written at FIX overwrites them later.
          if (mthi) begin
            hi_r <= wdata;
          end
          if (mtlo) begin
            lo_r <= wdata;
          end
          if (start) begin
            state_r   <= ST_CALC;
            busy_r    <= 1'b1;
            cnt_r     <= 6'd0;
            is_div_r  <= op[1];
            neg_a_r   <= op_signed_s & a[WIDTH-1];
            neg_xor_r <= op_signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            a_orig_r  <= a;
            rem_r     <= {(WIDTH+1){1'b0}};
            if (op[1]) begin
              mcand_r <= b_mag_s;
              acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
            end else begin
              mcand_r <= a_mag_s;
              acc_r   <= {{WIDTH{1'b0}}, b_mag_s};
            end
          end
        end
        ST_CALC: begin
          acc_r <= acc_next_s;
          rem_r <= rem_next_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == LAST_ITER) begin
            state_r <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_r    <= res_hi_s;
          lo_r    <= res_lo_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          cnt_r   <= 6'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Scoreboard bench for muldiv_unit. The stimulus process pushes the
//   expected {hi, lo} of each operation (from a plain-arithmetic reference
//   model) into a queue; a monitor pops and compares whenever done is seen.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_cmp;
  int          n_bad;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: returns {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] ux;
    logic [63:0] uy;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: res = 64'(sx * sy);
      2'b01: res = ux * uy;
      2'b10: begin
        if (y == 32'h0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          q   = sx / sy;
          r   = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          res = {32'(ux % uy), 32'(ux / uy)};
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_while_busy", 32'(busy), 32'h0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: hi=0x%08h lo=0x%08h with no operation outstanding", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hi", hi, mon_e[63:32]);
        check("result_lo", lo, mon_e[31:0]);
      end
    end
  end

  // Issue one operation at the current negedge and wait for its done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit inject, input bit with_mt);
    logic [63:0] e;
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    int          n;
    int          busy_n;
    bit          seen;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (with_mt) begin
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = $urandom;
      hi_m  = wdata;
      lo_m  = wdata;
    end
    e = model(o, x, y);
    exp_q.push_back(e);
    hold_hi = hi_m;
    hold_lo = lo_m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    while (!seen && n < 40) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (n == 0) check("done_dropped", 32'(done), 32'h0);
        if (n == 16) begin
          check("hold_hi", hi, hold_hi);
          check("hold_lo", lo, hold_lo);
        end
        if (inject) begin
          if (n == 4) begin
            start = 1'b1;
            op    = 2'b11;
            a     = 32'd100;
            b     = 32'd10;
          end
          if (n == 5) start = 1'b0;
          if (n == 9) begin
            mthi  = 1'b1;
            wdata = 32'h0000_DEAD;
          end
          if (n == 10) mthi = 1'b0;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles (op=%0d)", n, o);
    end else begin
      check("latency", 32'(n), 32'd33);
      check("busy_cycles", 32'(busy_n), 32'd33);
    end
    hi_m = e[63:32];
    lo_m = e[31:0];
  endtask

  // MTHI/MTLO while idle.
  task automatic idle_mt(input bit wh, input bit wl, input logic [31:0] d);
    mthi  = wh;
    mtlo  = wl;
    wdata = d;
    @(posedge clk);
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    if (wh) hi_m = d;
    if (wl) lo_m = d;
    check("mt_hi", hi, hi_m);
    check("mt_lo", lo, lo_m);
    check("mt_busy", 32'(busy), 32'h0);
    check("mt_done", 32'(done), 32'h0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          gap;
    int          dn;
    n_cmp = 0;
    n_bad = 0;
    hi_m  = 32'h0;
    lo_m  = 32'h0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = 32'h0;
    b     = 32'h0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);

    // start and mthi during a busy MULTU are ignored.
    idle_mt(1'b0, 1'b0, 32'h0);
    run_op(2'b01, 32'd3, 32'd4, 1'b1, 1'b0);
    idle_mt(1'b1, 1'b0, 32'h0000_DEAD);
    idle_mt(1'b0, 1'b1, 32'h0000_BEEF);

    // Back-to-back: the second start lands in the first done cycle.
    run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
    run_op(2'b11, 32'd42, 32'd5, 1'b0, 1'b0);

    // Randomized operations with occasional corner operands and moves.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(ro, ra, rb, 1'b0, ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset during CALC iteration 10.
    idle_mt(1'b1, 1'b1, 32'h1234_5678);
    start = 1'b1;
    op    = 2'b00;
    a     = 32'hFFFF_1234;
    b     = 32'h0000_5678;
    exp_q.push_back(model(2'b00, a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_done", 32'(done), 32'h0);
    check("async_rst_hi", hi, 32'h0);
    check("async_rst_lo", lo, 32'h0);
    exp_q.delete();
    hi_m = 32'h0;
    lo_m = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    dn  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("no_done_after_rst", 32'(dn), 32'h0);
    check("rst_hold_hi", hi, 32'h0);
    run_op(2'b01, 32'd9, 32'd11, 1'b0, 1'b0);
    run_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0, 1'b0);

    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
